adc_capture_lock: RTL and testbench
===================================

Name: adc_capture_lock

Overview:
Parametrised successor to the VGA ADC input stage. Runs in the ADC pixel clock domain and filters hsync/vsync with a configurable history width and polarity. It regenerates pixel_x/pixel_y counters and corrects them against the filtered sync edges within a tolerance window. A lock state machine gates pixel_valid, and the block emits frame/line start strobes to the downstream FIFO writer.

Parameters:
PRECISION, 11, width of x/y counters
PIXEL_SIZE, 16, pixel data width
X_RES / Y_RES, 800 / 600, active area
H_FRONT_PORCH / H_SYNC / H_BACK_PORCH, 40 / 128 / 88, horizontal timing; H_TOTAL = sum with X_RES (1056)
V_FRONT_PORCH / V_SYNC / V_BACK_PORCH, 1 / 4 / 23, vertical timing; V_TOTAL = 628
H_SYNC_POL / V_SYNC_POL, 1 / 1, active level of raw sync (1 = active high)
HISTORY_WIDTH, 5, sync filter length (≥2)
H_TOL / V_TOL, 2 / 2, max |error| accepted without correction
LOCK_LINES, 16, consecutive good hsync edges needed to lock
MISS_LIMIT, 4, consecutive bad hsync edges that drop lock
REQUIRE_LOCK, 1, 1 = pixel_valid only while locked

Ports:
hw_pixel_clk  in  1  pixel clock; all logic on posedge
hw_reset  in  1  asynchronous, active-high reset
hw_rgb_in  in  PIXEL_SIZE  raw ADC pixel
hw_hsync_in  in  1  raw hsync
hw_vsync_in  in  1  raw vsync
pixel_data  out  PIXEL_SIZE  registered pixel; 0 outside active area
pixel_x  out  PRECISION  x of pixel_data
pixel_y  out  PRECISION  y of pixel_data
pixel_valid  out  1  pixel_data is an active-area pixel
frame_start  out  1  one-cycle strobe with pixel (0,0)
line_start  out  1  one-cycle strobe with every pixel x=0 in active rows
locked  out  1  lock FSM in LOCKED

Behaviour:
- Reset (async assert, sync-released use): x=y=0; histories all inactive level; filtered syncs inactive; FSM SEARCH; counters 0; all outputs 0.
- Filter: history shifts in raw sync each cycle. Filtered sync goes active when all HISTORY_WIDTH bits equal the active level and goes inactive when all bits are inactive. Leading edge = cycle the filtered state goes active.
- Counters: x increments and wraps at H_TOTAL-1→0; on wrap y increments and wraps at V_TOTAL-1→0.
- H correction at leading hsync edge, with R_H = X_RES+H_FRONT_PORCH+HISTORY_WIDTH (845):
  - If |x−R_H| ≤ H_TOL: the edge is good and the normal increment applies.
  - Otherwise the edge is bad and x_next = R_H+1.
  - If the correction lands in a wrap cycle, the correction wins and y does not increment.
- V correction at leading vsync edge, with R_V = Y_RES+V_FRONT_PORCH (601):
  - If |y−R_V| > V_TOL, y_next = R_V.
  - This overrides any same-cycle y increment.
- Error arithmetic is unsigned compare both ways; no wrap-around distance.
- Lock FSM:
  - SEARCH: good edge increments good_cnt, bad edge clears it. good_cnt==LOCK_LINES → LOCKED, clear miss_cnt.
  - LOCKED: bad edge increments miss_cnt, good edge clears it. miss_cnt==MISS_LIMIT → SEARCH, clear good_cnt.
  - Any state: no hsync leading edge for 2*H_TOTAL cycles (timeout counter, reset on each edge) → SEARCH, clear both counters.
  - locked = (state==LOCKED), registered.
- Output pipeline, latency 1 cycle: hw_rgb_in and the current x/y register into pixel_data/pixel_x/pixel_y.
  - pixel_valid = x<X_RES && y<Y_RES && (locked || !REQUIRE_LOCK).
  - frame_start = pixel_valid && x==0 && y==0.
  - line_start = pixel_valid && x==0.
  - pixel_data is forced to 0 when not pixel_valid.

Optional Feature:
ADC_CAPTURE_STATS_EN:
- Defined: adds outputs line_length [PRECISION-1:0] and frame_lines [PRECISION-1:0], reset 0.
  - line_length = cycles between consecutive filtered hsync leading edges, saturating at all-ones.
  - frame_lines = hsync edges between consecutive vsync leading edges.
  - Both update on the respective edge.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset asserted mid-line at x=300 → same-cycle outputs 0, locked 0, pixel_x/y 0; after release, counting restarts from 0.
- Clean 800x600 timing, active-high syncs, counter phase mismatched → first hsync edge forces x to 846. locked rises after 16 good edges; thereafter exactly 800 pixel_valid per row, 600 rows, one frame_start per 663168 cycles.
- Locked, a single hsync edge shifted +1 cycle → no correction; locked stays 1. Shift +10 cycles → x corrected; after 4 consecutive shifted edges locked drops.
- 3-cycle hsync glitch mid-line (HISTORY_WIDTH=5) → filter ignores it; x unaffected; no lock change.
- hsync stopped while locked → locked falls 2112 cycles after the last edge; pixel_valid stays 0 (REQUIRE_LOCK=1).
- H_SYNC_POL=0 with an inverted sync stream → identical lock and valid timing to the active-high case.

Source files
------------

// File: rtl/adc_capture_lock.sv
// -----------------------------------------------------------------------------
// adc_capture_lock
//
// Pixel-clock-domain capture stage for a VGA-style ADC. Raw hsync/vsync are
// filtered through a HISTORY_WIDTH-deep history, the local pixel_x/pixel_y
// counters are regenerated and pulled back into phase at filtered sync leading
// edges, and a lock state machine decides when captured pixels are trusted.
//
// Optional feature macro: ADC_CAPTURE_STATS_EN adds line_length/frame_lines.
//
// Ports:
//   hw_pixel_clk  in   pixel clock, all logic on posedge
//   hw_reset      in   asynchronous, active-high reset
//   hw_rgb_in     in   raw ADC pixel [PIXEL_SIZE]
//   hw_hsync_in   in   raw hsync (active level H_SYNC_POL)
//   hw_vsync_in   in   raw vsync (active level V_SYNC_POL)
//   pixel_data    out  registered pixel, 0 outside the active area
//   pixel_x       out  x coordinate of pixel_data
//   pixel_y       out  y coordinate of pixel_data
//   pixel_valid   out  pixel_data is an active-area pixel
//   frame_start   out  one-cycle strobe with pixel (0,0)
//   line_start    out  one-cycle strobe with every valid pixel at x=0
//   locked        out  lock FSM is in LOCKED
//   line_length   out  (stats) cycles between filtered hsync leading edges
//   frame_lines   out  (stats) hsync edges between vsync leading edges
// -----------------------------------------------------------------------------
module adc_capture_lock #(
    parameter int PRECISION     = 11,
    parameter int PIXEL_SIZE    = 16,
    parameter int X_RES         = 800,
    parameter int Y_RES         = 600,
    parameter int H_FRONT_PORCH = 40,
    parameter int H_SYNC        = 128,
    parameter int H_BACK_PORCH  = 88,
    parameter int V_FRONT_PORCH = 1,
    parameter int V_SYNC        = 4,
    parameter int V_BACK_PORCH  = 23,
    parameter int H_SYNC_POL    = 1,
    parameter int V_SYNC_POL    = 1,
    parameter int HISTORY_WIDTH = 5,
    parameter int H_TOL         = 2,
    parameter int V_TOL         = 2,
    parameter int LOCK_LINES    = 16,
    parameter int MISS_LIMIT    = 4,
    parameter int REQUIRE_LOCK  = 1
) (
    input  logic                  hw_pixel_clk,
    input  logic                  hw_reset,
    input  logic [PIXEL_SIZE-1:0] hw_rgb_in,
    input  logic                  hw_hsync_in,
    input  logic                  hw_vsync_in,
    output logic [PIXEL_SIZE-1:0] pixel_data,
    output logic [PRECISION-1:0]  pixel_x,
    output logic [PRECISION-1:0]  pixel_y,
    output logic                  pixel_valid,
    output logic                  frame_start,
    output logic                  line_start,
    output logic                  locked
`ifdef ADC_CAPTURE_STATS_EN
    ,
    output logic [PRECISION-1:0]  line_length,
    output logic [PRECISION-1:0]  frame_lines
`endif
);

    localparam int H_TOTAL = X_RES + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int V_TOTAL = Y_RES + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    // Expected x at the filtered leading edge: raw edge position plus the
    // filter delay of HISTORY_WIDTH cycles.
    localparam int R_H     = X_RES + H_FRONT_PORCH + HISTORY_WIDTH;
    localparam int R_V     = Y_RES + V_FRONT_PORCH;
    localparam int TOUT_W  = $clog2(2 * H_TOTAL + 1);
    localparam int GOOD_W  = $clog2(LOCK_LINES + 1);
    localparam int MISS_W  = $clog2(MISS_LIMIT + 1);

    localparam logic [PRECISION-1:0] ZERO_P     = PRECISION'(0);
    localparam logic [PRECISION-1:0] ONE_P      = PRECISION'(1);
    localparam logic [PRECISION-1:0] X_RES_P    = PRECISION'(X_RES);
    localparam logic [PRECISION-1:0] Y_RES_P    = PRECISION'(Y_RES);
    localparam logic [PRECISION-1:0] H_LAST_P   = PRECISION'(H_TOTAL - 1);
    localparam logic [PRECISION-1:0] V_LAST_P   = PRECISION'(V_TOTAL - 1);
    localparam logic [PRECISION-1:0] R_H_P      = PRECISION'(R_H);
    localparam logic [PRECISION-1:0] R_H_NEXT_P = PRECISION'(R_H + 1);
    localparam logic [PRECISION-1:0] R_V_P      = PRECISION'(R_V);
    localparam logic [PRECISION-1:0] H_TOL_P    = PRECISION'(H_TOL);
    localparam logic [PRECISION-1:0] V_TOL_P    = PRECISION'(V_TOL);
    localparam logic [GOOD_W-1:0]    GOOD_LAST  = GOOD_W'(LOCK_LINES - 1);
    localparam logic [MISS_W-1:0]    MISS_LAST  = MISS_W'(MISS_LIMIT - 1);
    localparam logic [TOUT_W-1:0]    TOUT_LAST  = TOUT_W'(2 * H_TOTAL - 1);
    localparam logic [HISTORY_WIDTH-1:0] H_ACT_PAT =
        (H_SYNC_POL != 0) ? {HISTORY_WIDTH{1'b1}} : {HISTORY_WIDTH{1'b0}};
    localparam logic [HISTORY_WIDTH-1:0] V_ACT_PAT =
        (V_SYNC_POL != 0) ? {HISTORY_WIDTH{1'b1}} : {HISTORY_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    logic [HISTORY_WIDTH-1:0] hsync_hist_r;
    logic [HISTORY_WIDTH-1:0] vsync_hist_r;
    logic                     hsync_filt_r;   // 1 = filtered sync active
    logic                     vsync_filt_r;
    logic [PRECISION-1:0]     x_r;
    logic [PRECISION-1:0]     y_r;
    lock_state_t              state_r;
    logic [GOOD_W-1:0]        good_cnt_r;
    logic [MISS_W-1:0]        miss_cnt_r;
    logic [TOUT_W-1:0]        tout_r;

    logic                     h_all_act_s;
    logic                     h_all_idle_s;
    logic                     v_all_act_s;
    logic                     v_all_idle_s;
    logic                     h_edge_s;
    logic                     v_edge_s;
    logic [PRECISION-1:0]     h_err_s;
    logic [PRECISION-1:0]     v_err_s;
    logic                     h_good_s;
    logic                     x_wrap_s;
    logic                     y_inc_s;
    logic [PRECISION-1:0]     y_step_s;
    logic [PRECISION-1:0]     x_next_s;
    logic [PRECISION-1:0]     y_next_s;
    logic                     pix_valid_s;

    assign h_all_act_s  = (hsync_hist_r == H_ACT_PAT);
    assign h_all_idle_s = (hsync_hist_r == ~H_ACT_PAT);
    assign v_all_act_s  = (vsync_hist_r == V_ACT_PAT);
    assign v_all_idle_s = (vsync_hist_r == ~V_ACT_PAT);
    // Leading edge is the cycle in which the filtered state is about to go active.
    assign h_edge_s     = h_all_act_s && !hsync_filt_r;
    assign v_edge_s     = v_all_act_s && !vsync_filt_r;

    // Sync filters: shift history and update the filtered state with hysteresis.
    always_ff @(posedge hw_pixel_clk or posedge hw_reset) begin
        if (hw_reset) begin
            hsync_hist_r <= ~H_ACT_PAT;
            vsync_hist_r <= ~V_ACT_PAT;
            hsync_filt_r <= 1'b0;
            vsync_filt_r <= 1'b0;
        end else begin
            hsync_hist_r <= {hsync_hist_r[HISTORY_WIDTH-2:0], hw_hsync_in};
            vsync_hist_r <= {vsync_hist_r[HISTORY_WIDTH-2:0], hw_vsync_in};
            if (h_all_act_s) begin
                hsync_filt_r <= 1'b1;
            end else if (h_all_idle_s) begin
                hsync_filt_r <= 1'b0;
            end else begin
                hsync_filt_r <= hsync_filt_r;
            end
            if (v_all_act_s) begin
                vsync_filt_r <= 1'b1;
            end else if (v_all_idle_s) begin
                vsync_filt_r <= 1'b0;
            end else begin
                vsync_filt_r <= vsync_filt_r;
            end
        end
    end

    // Next x/y: free-running raster with phase correction at sync edges.
    always_comb begin
        h_err_s  = (x_r >= R_H_P) ? (x_r - R_H_P) : (R_H_P - x_r);
        v_err_s  = (y_r >= R_V_P) ? (y_r - R_V_P) : (R_V_P - y_r);
        h_good_s = (h_err_s <= H_TOL_P);
        x_wrap_s = (x_r == H_LAST_P);
        if (h_edge_s && !h_good_s) begin
            // A correction replaces the increment, including a pending wrap.
            x_next_s = R_H_NEXT_P;
            y_inc_s  = 1'b0;
        end else begin
            x_next_s = x_wrap_s ? ZERO_P : (x_r + ONE_P);
            y_inc_s  = x_wrap_s;
        end
        if (y_inc_s) begin
            y_step_s = (y_r == V_LAST_P) ? ZERO_P : (y_r + ONE_P);
        end else begin
            y_step_s = y_r;
        end
        if (v_edge_s && (v_err_s > V_TOL_P)) begin
            y_next_s = R_V_P;
        end else begin
            y_next_s = y_step_s;
        end
    end

    // Raster counters.
    always_ff @(posedge hw_pixel_clk or posedge hw_reset) begin
        if (hw_reset) begin
            x_r <= ZERO_P;
            y_r <= ZERO_P;
        end else begin
            x_r <= x_next_s;
            y_r <= y_next_s;
        end
    end

    // Lock FSM: qualifies hsync edges, tracks good/miss streaks and edge timeout.
    always_ff @(posedge hw_pixel_clk or posedge hw_reset) begin
        if (hw_reset) begin
            state_r    <= SEARCH;
            good_cnt_r <= {GOOD_W{1'b0}};
            miss_cnt_r <= {MISS_W{1'b0}};
            tout_r     <= {TOUT_W{1'b0}};
            locked     <= 1'b0;
        end else if (h_edge_s) begin
            tout_r <= {TOUT_W{1'b0}};
            case (state_r)
                SEARCH: begin
                    if (!h_good_s) begin
                        good_cnt_r <= {GOOD_W{1'b0}};
                    end else if (good_cnt_r == GOOD_LAST) begin
                        // This edge completes the LOCK_LINES streak.
                        state_r    <= LOCKED;
                        locked     <= 1'b1;
                        good_cnt_r <= {GOOD_W{1'b0}};
                        miss_cnt_r <= {MISS_W{1'b0}};
                    end else begin
                        good_cnt_r <= good_cnt_r + GOOD_W'(1);
                    end
                end
                LOCKED: begin
                    if (h_good_s) begin
                        miss_cnt_r <= {MISS_W{1'b0}};
                    end else if (miss_cnt_r == MISS_LAST) begin
                        state_r    <= SEARCH;
                        locked     <= 1'b0;
                        good_cnt_r <= {GOOD_W{1'b0}};
                        miss_cnt_r <= {MISS_W{1'b0}};
                    end else begin
                        miss_cnt_r <= miss_cnt_r + MISS_W'(1);
                    end
                end
                default: begin
                    state_r    <= SEARCH;
                    locked     <= 1'b0;
                    good_cnt_r <= {GOOD_W{1'b0}};
                    miss_cnt_r <= {MISS_W{1'b0}};
                end
            endcase
        end else if (tout_r == TOUT_LAST) begin
            // Saturated timeout holds the FSM in SEARCH until edges return.
            state_r    <= SEARCH;
            locked     <= 1'b0;
            good_cnt_r <= {GOOD_W{1'b0}};
            miss_cnt_r <= {MISS_W{1'b0}};
        end else begin
            tout_r <= tout_r + TOUT_W'(1);
        end
    end

    assign pix_valid_s = (x_r < X_RES_P) && (y_r < Y_RES_P) &&
                         (locked || (REQUIRE_LOCK == 0));

    // Output pipeline: one-cycle registered pixel, coordinates and strobes.
    always_ff @(posedge hw_pixel_clk or posedge hw_reset) begin
        if (hw_reset) begin
            pixel_data  <= {PIXEL_SIZE{1'b0}};
            pixel_x     <= ZERO_P;
            pixel_y     <= ZERO_P;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            pixel_data  <= pix_valid_s ? hw_rgb_in : {PIXEL_SIZE{1'b0}};
            pixel_x     <= x_r;
            pixel_y     <= y_r;
            pixel_valid <= pix_valid_s;
            frame_start <= pix_valid_s && (x_r == ZERO_P) && (y_r == ZERO_P);
            line_start  <= pix_valid_s && (x_r == ZERO_P);
        end
    end

`ifdef ADC_CAPTURE_STATS_EN
    logic [PRECISION-1:0] line_cnt_r;
    logic [PRECISION-1:0] hedge_cnt_r;

    // Timing statistics: measured line length and lines per frame.
    always_ff @(posedge hw_pixel_clk or posedge hw_reset) begin
        if (hw_reset) begin
            line_cnt_r  <= ZERO_P;
            hedge_cnt_r <= ZERO_P;
            line_length <= ZERO_P;
            frame_lines <= ZERO_P;
        end else begin
            if (h_edge_s) begin
                line_length <= (&line_cnt_r) ? line_cnt_r : (line_cnt_r + ONE_P);
                line_cnt_r  <= ZERO_P;
            end else begin
                line_length <= line_length;
                line_cnt_r  <= (&line_cnt_r) ? line_cnt_r : (line_cnt_r + ONE_P);
            end
            if (v_edge_s) begin
                // A same-cycle hsync edge still belongs to the frame just closed.
                frame_lines <= hedge_cnt_r + (h_edge_s ? ONE_P : ZERO_P);
                hedge_cnt_r <= ZERO_P;
            end else if (h_edge_s) begin
                frame_lines <= frame_lines;
                hedge_cnt_r <= hedge_cnt_r + ONE_P;
            end else begin
                frame_lines <= frame_lines;
                hedge_cnt_r <= hedge_cnt_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_capture_lock.sv
`timescale 1ns/1ps
module tb_adc_capture_lock;

    localparam int HT = 1056;
    localparam int VT = 628;
    localparam int HW = 5;
    localparam int RH = 845;
    localparam int RV = 601;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rgb = 16'h0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic        hs_n = 1'b1;
    logic        vs_n = 1'b1;

    logic [15:0] a_data, b_data;
    logic [10:0] a_px, a_py, b_px, b_py;
    logic        a_valid, a_fs, a_ls, a_locked;
    logic        b_valid, b_fs, b_ls, b_locked;
`ifdef ADC_CAPTURE_STATS_EN
    logic [10:0] a_ll, a_fl, b_ll, b_fl;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    adc_capture_lock dut_a (
        .hw_pixel_clk(clk), .hw_reset(rst), .hw_rgb_in(rgb),
        .hw_hsync_in(hs), .hw_vsync_in(vs),
        .pixel_data(a_data), .pixel_x(a_px), .pixel_y(a_py),
        .pixel_valid(a_valid), .frame_start(a_fs), .line_start(a_ls),
        .locked(a_locked)
`ifdef ADC_CAPTURE_STATS_EN
        , .line_length(a_ll), .frame_lines(a_fl)
`endif
    );

    adc_capture_lock #(.H_SYNC_POL(0), .V_SYNC_POL(0)) dut_b (
        .hw_pixel_clk(clk), .hw_reset(rst), .hw_rgb_in(rgb),
        .hw_hsync_in(hs_n), .hw_vsync_in(vs_n),
        .pixel_data(b_data), .pixel_x(b_px), .pixel_y(b_py),
        .pixel_valid(b_valid), .frame_start(b_fs), .line_start(b_ls),
        .locked(b_locked)
`ifdef ADC_CAPTURE_STATS_EN
        , .line_length(b_ll), .frame_lines(b_fl)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- video source -----------------------------------------
    int sx = 0, sy = 595, line = 0;

    function automatic int delta_of(input int l);
        case (l)
            35:             return 1;
            36:             return -1;
            44, 45, 46, 47: return 10;
            default:        return 0;
        endcase
    endfunction

    task automatic drive();
        bit h;
        h = (sx >= 840 && sx < 968 && !(line >= 70 && line <= 72)) ||
            (line == 40 && sx >= 400 && sx < 403);
        hs   = h;
        hs_n = ~h;
        vs   = (sy >= 601 && sy < 605);
        vs_n = ~(sy >= 601 && sy < 605);
        rgb  = 16'($urandom);
    endtask

    initial begin
        drive();
        forever begin
            @(negedge clk);
            if (sx >= HT - 1 + delta_of(line)) begin
                sx = 0;
                line++;
                sy = (sy == VT - 1) ? 0 : sy + 1;
            end else begin
                sx++;
            end
            drive();
        end
    end

    // ---------------- behavioural reference model ---------------------------
    int  mx, my, mg, mm, msince, hact, hin, vact, vin;
    bit  mlk, mhf, mvf;
    logic [15:0] exp_data;
    logic [10:0] exp_px, exp_py;
    logic        exp_valid, exp_fs, exp_ls, exp_locked;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mg = 0; mm = 0; msince = 0;
        hact = 0; hin = HW; vact = 0; vin = HW;
        mlk = 1'b0; mhf = 1'b0; mvf = 1'b0;
        exp_data = 16'h0; exp_px = 11'd0; exp_py = 11'd0;
        exp_valid = 1'b0; exp_fs = 1'b0; exp_ls = 1'b0; exp_locked = 1'b0;
    endtask

    task automatic model_step();
        bit hedge, vedge, hgood, wrap;
        int nx, ny;
        exp_valid = (mx < 800) && (my < 600) && mlk;
        exp_px    = 11'(mx);
        exp_py    = 11'(my);
        exp_data  = exp_valid ? rgb : 16'h0;
        exp_fs    = exp_valid && (mx == 0) && (my == 0);
        exp_ls    = exp_valid && (mx == 0);
        hedge = (hact >= HW) && !mhf;
        vedge = (vact >= HW) && !mvf;
        hgood = iabs(mx - RH) <= 2;
        wrap  = (mx == HT - 1);
        if (hedge && !hgood) begin
            nx = RH + 1;
            ny = my;
        end else begin
            nx = wrap ? 0 : mx + 1;
            ny = wrap ? ((my == VT - 1) ? 0 : my + 1) : my;
        end
        if (vedge && iabs(my - RV) > 2) ny = RV;
        if (hedge) begin
            msince = 0;
            if (!mlk) begin
                mg = hgood ? mg + 1 : 0;
                if (mg == 16) begin mlk = 1'b1; mg = 0; mm = 0; end
            end else begin
                mm = hgood ? 0 : mm + 1;
                if (mm == 4) begin mlk = 1'b0; mg = 0; mm = 0; end
            end
        end else begin
            msince++;
            if (msince >= 2 * HT) begin mlk = 1'b0; mg = 0; mm = 0; end
        end
        exp_locked = mlk;
        if (hact >= HW) mhf = 1'b1; else if (hin >= HW) mhf = 1'b0;
        if (vact >= HW) mvf = 1'b1; else if (vin >= HW) mvf = 1'b0;
        if (hs) begin hact = (hact < HW) ? hact + 1 : HW; hin = 0; end
        else    begin hin = (hin < HW) ? hin + 1 : HW; hact = 0; end
        if (vs) begin vact = (vact < HW) ? vact + 1 : HW; vin = 0; end
        else    begin vin = (vin < HW) ? vin + 1 : HW; vact = 0; end
        mx = nx;
        my = ny;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- per-cycle compare + row monitors ----------------------
    int v_row0 = 0, v_row1 = 0, fs_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("a.pixel_data",  a_data,   exp_data);
            chk("a.pixel_x",     a_px,     exp_px);
            chk("a.pixel_y",     a_py,     exp_py);
            chk("a.pixel_valid", a_valid,  exp_valid);
            chk("a.frame_start", a_fs,     exp_fs);
            chk("a.line_start",  a_ls,     exp_ls);
            chk("a.locked",      a_locked, exp_locked);
            chk("b.pixel_data",  b_data,   exp_data);
            chk("b.pixel_x",     b_px,     exp_px);
            chk("b.pixel_y",     b_py,     exp_py);
            chk("b.pixel_valid", b_valid,  exp_valid);
            chk("b.locked",      b_locked, exp_locked);
            if (a_valid && a_py == 11'd0) v_row0++;
            if (a_valid && a_py == 11'd1) v_row1++;
            if (a_fs) fs_cnt++;
        end
    end

    // ---------------- directed checkpoints ----------------------------------
    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic wait_pos(input int l, input int x);
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk);
            #1;
            if (line == l && sx == x) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_pos: source position line %0d x %0d never reached", l, x);
        finish_run();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        // Mid-line asynchronous reset with the raster counter at x=300.
        #3 rst = 1'b1;
        #1;
        chk("rst.pixel_x",     a_px,     32'd0);
        chk("rst.pixel_y",     a_py,     32'd0);
        chk("rst.pixel_data",  a_data,   32'd0);
        chk("rst.pixel_valid", a_valid,  32'd0);
        chk("rst.line_start",  a_ls,     32'd0);
        chk("rst.locked",      a_locked, 32'd0);
        chk("rst.b_locked",    b_locked, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("restart.x0", a_px, 32'd0);
        @(posedge clk); #1;
        chk("restart.x1", a_px, 32'd1);

        wait_pos(0, 846);
        chk("first_edge.x", a_px, 32'd846);
        chk("first_edge.lock", a_locked, 32'd0);

        wait_pos(10, 100);
        chk("vcorr.y", a_py, 32'd605);
        chk("vcorr.x", a_px, 32'd100);

        wait_pos(16, 844);
        chk("prelock.a", a_locked, 32'd0);
        @(posedge clk); #1;
        chk("lock16.a", a_locked, 32'd1);
        chk("lock16.b", b_locked, 32'd1);

        wait_pos(41, 500);
        chk("glitch_shift1.lock", a_locked, 32'd1);
        chk("glitch.x", a_px, 32'd500);

        wait_pos(48, 846);
        chk("miss4.lock", a_locked, 32'd0);

        wait_pos(69, 845);
        chk("prestop.lock", a_locked, 32'd1);
        n = 0;
        while (n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (a_locked == 1'b0) break;
        end
        chk("timeout.cycles", n, 32'd2112);
        chk("timeout.b_lock", b_locked, 32'd0);
        chk("timeout.valid", a_valid, 32'd0);

        wait_pos(74, 0);
        chk("row0.valid_count", v_row0, 32'd800);
        chk("row1.valid_count", v_row1, 32'd800);
        chk("frame_start.count", fs_cnt, 32'd1);
        finish_run();
    end

endmodule
